// File: rtl/wb_queue_if.sv
// Bus bundle for the write-back queue: mem/alu producer channels, register-file
// write port, bypass lookup and occupancy.
interface wb_queue_if #(
    parameter int ADDR_LEN  = 5,
    parameter int WORD_SIZE = 32,
    parameter int DEPTH     = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                 mem_valid_i;
    logic [ADDR_LEN-1:0]  mem_addr_i;
    logic [WORD_SIZE-1:0] mem_data_i;
    logic                 mem_ready_o;

    logic                 alu_valid_i;
    logic [ADDR_LEN-1:0]  alu_addr_i;
    logic [WORD_SIZE-1:0] alu_data_i;
    logic                 alu_ready_o;

    logic [ADDR_LEN-1:0]  dst_addr_o;
    logic [WORD_SIZE-1:0] data_o;
    logic                 w_en;

    logic [ADDR_LEN-1:0]  fwd_addr_i;
    logic                 fwd_hit_o;
    logic [WORD_SIZE-1:0] fwd_data_o;

    logic [CNT_W-1:0]     count_o;

    modport master (
        output mem_valid_i, mem_addr_i, mem_data_i,
        output alu_valid_i, alu_addr_i, alu_data_i,
        output fwd_addr_i,
        input  mem_ready_o, alu_ready_o,
        input  dst_addr_o, data_o, w_en,
        input  fwd_hit_o, fwd_data_o,
        input  count_o
    );

    modport slave (
        input  mem_valid_i, mem_addr_i, mem_data_i,
        input  alu_valid_i, alu_addr_i, alu_data_i,
        input  fwd_addr_i,
        output mem_ready_o, alu_ready_o,
        output dst_addr_o, data_o, w_en,
        output fwd_hit_o, fwd_data_o,
        output count_o
    );
endinterface

// File: rtl/wb_queue.sv
// Write-back queue: merges memory and ALU results in program order, drains one
// entry per cycle into the register-file write port, and offers a bypass lookup.
module wb_queue #(
    parameter int ADDR_LEN   = 5,
    parameter int WORD_SIZE  = 32,
    parameter int DEPTH      = 4,
    parameter int DISCARD_R0 = 1
) (
    input logic       clk,
    input logic       rst_n,
    wb_queue_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]        rptr_q, rptr_d;
    logic [PW-1:0]        wptr_q, wptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic [ADDR_LEN-1:0]  dst_q, dst_d;
    logic [WORD_SIZE-1:0] data_q, data_d;
    logic                 w_en_q, w_en_d;

    logic [ADDR_LEN-1:0]  addr_mem [DEPTH];
    logic [WORD_SIZE-1:0] data_mem [DEPTH];

    logic [CW-1:0]        free_w;
    logic                 mem_ready, alu_ready;
    logic                 mem_fire, alu_fire;
    logic                 mem_keep, alu_keep;
    logic                 pop;
    logic [PW-1:0]        alu_slot;

    logic                 hit;
    logic [WORD_SIZE-1:0] fwd_data;
    logic [PW-1:0]        idx;

    // Readiness looks only at registered occupancy, never at this cycle's pop.
    assign free_w    = CW'(DEPTH) - count_q;
    assign mem_ready = rst_n && (free_w != '0);
    assign alu_ready = rst_n && ((free_w >= CW'(2)) ||
                                 ((free_w != '0) && !bus.mem_valid_i));

    assign mem_fire = bus.mem_valid_i && mem_ready;
    assign alu_fire = bus.alu_valid_i && alu_ready;
    assign mem_keep = mem_fire && !((DISCARD_R0 != 0) && (bus.mem_addr_i == '0));
    assign alu_keep = alu_fire && !((DISCARD_R0 != 0) && (bus.alu_addr_i == '0));
    assign pop      = (count_q != '0);

    // The alu entry lands behind the mem entry when both are kept.
    assign alu_slot = wptr_q + PW'(mem_keep);

    always_comb begin
        rptr_d  = rptr_q;
        wptr_d  = wptr_q + PW'(mem_keep) + PW'(alu_keep);
        count_d = count_q + CW'(mem_keep) + CW'(alu_keep) - CW'(pop);
        dst_d   = dst_q;
        data_d  = data_q;
        w_en_d  = 1'b0;
        if (pop) begin
            rptr_d = rptr_q + PW'(1);
            dst_d  = addr_mem[rptr_q];
            data_d = data_mem[rptr_q];
            w_en_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
            dst_q   <= '0;
            data_q  <= '0;
            w_en_q  <= 1'b0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
            dst_q   <= dst_d;
            data_q  <= data_d;
            w_en_q  <= w_en_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_keep) begin
            addr_mem[wptr_q] <= bus.mem_addr_i;
            data_mem[wptr_q] <= bus.mem_data_i;
        end
        if (alu_keep) begin
            addr_mem[alu_slot] <= bus.alu_addr_i;
            data_mem[alu_slot] <= bus.alu_data_i;
        end
    end

    // Bypass: output register is oldest, then queue entries head to tail; later matches override.
    always_comb begin
        hit      = 1'b0;
        fwd_data = '0;
        idx      = rptr_q;
        if (w_en_q && (dst_q == bus.fwd_addr_i)) begin
            hit      = 1'b1;
            fwd_data = data_q;
        end
        for (int i = 0; i < DEPTH; i++) begin
            idx = rptr_q + PW'(i);
            if ((CW'(i) < count_q) && (addr_mem[idx] == bus.fwd_addr_i)) begin
                hit      = 1'b1;
                fwd_data = data_mem[idx];
            end
        end
        if ((DISCARD_R0 != 0) && (bus.fwd_addr_i == '0)) begin
            hit      = 1'b0;
            fwd_data = '0;
        end
    end

    assign bus.mem_ready_o = mem_ready;
    assign bus.alu_ready_o = alu_ready;
    assign bus.dst_addr_o  = dst_q;
    assign bus.data_o      = data_q;
    assign bus.w_en        = w_en_q;
    assign bus.fwd_hit_o   = hit;
    assign bus.fwd_data_o  = fwd_data;
    assign bus.count_o     = count_q;
endmodule

// File: tb/tb_wb_queue.sv
// Self-checking bench for wb_queue: directed vector table, hand-written reset and
// wrap sequences, then random traffic against a queue-based reference model.
module tb_wb_queue;
    localparam int AL = 5;
    localparam int WS = 32;
    localparam int DP = 4;

    logic clk;
    logic rst_n;

    wb_queue_if #(.ADDR_LEN(AL), .WORD_SIZE(WS), .DEPTH(DP)) bus ();

    wb_queue #(.ADDR_LEN(AL), .WORD_SIZE(WS), .DEPTH(DP), .DISCARD_R0(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic          s_mr, s_ar, s_hit, s_wen;
    logic [WS-1:0] s_fd, s_dat;
    logic [2:0]    s_cnt;
    logic [AL-1:0] s_dst;

    typedef struct {
        logic mv; logic [AL-1:0] ma; logic [WS-1:0] md;
        logic av; logic [AL-1:0] aa; logic [WS-1:0] ad;
        logic [AL-1:0] fa;
        logic mr; logic ar; logic hit; logic [WS-1:0] fd;
        logic [2:0] cnt; logic wen; logic [AL-1:0] dst; logic [WS-1:0] dat;
    } vec_t;

    typedef struct packed {
        logic [AL-1:0] a;
        logic [WS-1:0] d;
    } ent_t;

    vec_t vt [19];
    ent_t mq [$];
    ent_t got [$];
    logic          out_v;
    logic [AL-1:0] out_a;
    logic [WS-1:0] out_d;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else
            pass_cnt++;
    endtask

    // Called at a falling edge: drive, sample comb outputs, cross one rising edge, sample registers.
    task automatic cyc(input logic mv, input logic [AL-1:0] ma, input logic [WS-1:0] md,
                       input logic av, input logic [AL-1:0] aa, input logic [WS-1:0] ad,
                       input logic [AL-1:0] fa);
        bus.mem_valid_i = mv; bus.mem_addr_i = ma; bus.mem_data_i = md;
        bus.alu_valid_i = av; bus.alu_addr_i = aa; bus.alu_data_i = ad;
        bus.fwd_addr_i  = fa;
        #1;
        s_mr = bus.mem_ready_o; s_ar = bus.alu_ready_o;
        s_hit = bus.fwd_hit_o;  s_fd = bus.fwd_data_o;
        @(posedge clk);
        @(negedge clk);
        s_cnt = bus.count_o; s_wen = bus.w_en;
        s_dst = bus.dst_addr_o; s_dat = bus.data_o;
    endtask

    task automatic idle(input logic [AL-1:0] fa);
        cyc(1'b0, '0, '0, 1'b0, '0, '0, fa);
    endtask

    task automatic sample_now();
        #1;
        s_mr = bus.mem_ready_o; s_ar = bus.alu_ready_o;
        s_hit = bus.fwd_hit_o;  s_fd = bus.fwd_data_o;
        s_cnt = bus.count_o; s_wen = bus.w_en;
        s_dst = bus.dst_addr_o; s_dat = bus.data_o;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_cnt"}, 64'(s_cnt), 64'd0);
        chk({tag, "_wen"}, 64'(s_wen), 64'd0);
        chk({tag, "_dst"}, 64'(s_dst), 64'd0);
        chk({tag, "_dat"}, 64'(s_dat), 64'd0);
        chk({tag, "_hit"}, 64'(s_hit), 64'd0);
        chk({tag, "_mr"},  64'(s_mr),  64'd0);
        chk({tag, "_ar"},  64'(s_ar),  64'd0);
    endtask

    initial begin
        logic [AL-1:0] ra, rb, rf;
        logic [WS-1:0] rda, rdb;
        logic rmv, rav, e_mr, e_ar, e_hit, m_ok, a_ok;
        logic [WS-1:0] e_fd;
        int free;

        // mv ma md | av aa ad | fa || mr ar hit fd || cnt wen dst dat (after the edge)
        vt[0]  = '{0,0,0,              0,0,0,              0, 1,1,0,0,              0,0,0,0};
        vt[1]  = '{1,3,32'hA5A5A5A5,   0,0,0,              3, 1,1,0,0,              1,0,0,0};
        vt[2]  = '{0,0,0,              0,0,0,              3, 1,1,1,32'hA5A5A5A5,   0,1,3,32'hA5A5A5A5};
        vt[3]  = '{0,0,0,              0,0,0,              3, 1,1,1,32'hA5A5A5A5,   0,0,3,32'hA5A5A5A5};
        vt[4]  = '{1,5,32'h11,         1,5,32'h22,         5, 1,1,0,0,              2,0,3,32'hA5A5A5A5};
        vt[5]  = '{0,0,0,              0,0,0,              5, 1,1,1,32'h22,         1,1,5,32'h11};
        vt[6]  = '{0,0,0,              0,0,0,              5, 1,1,1,32'h22,         0,1,5,32'h22};
        vt[7]  = '{0,0,0,              0,0,0,              5, 1,1,1,32'h22,         0,0,5,32'h22};
        vt[8]  = '{0,0,0,              1,0,32'hFFFFFFFF,   0, 1,1,0,0,              0,0,5,32'h22};
        vt[9]  = '{0,0,0,              0,0,0,              0, 1,1,0,0,              0,0,5,32'h22};
        vt[10] = '{1,1,32'h101,        1,2,32'h102,        1, 1,1,0,0,              2,0,5,32'h22};
        vt[11] = '{1,3,32'h103,        1,4,32'h104,        2, 1,1,1,32'h102,        3,1,1,32'h101};
        vt[12] = '{1,5,32'h105,        1,6,32'h106,        1, 1,0,1,32'h101,        3,1,2,32'h102};
        vt[13] = '{1,6,32'h107,        0,0,0,              6, 1,0,0,0,              3,1,3,32'h103};
        vt[14] = '{0,0,0,              1,7,32'h108,        6, 1,1,1,32'h107,        3,1,4,32'h104};
        vt[15] = '{0,0,0,              0,0,0,              7, 1,1,1,32'h108,        2,1,5,32'h105};
        vt[16] = '{0,0,0,              0,0,0,              5, 1,1,1,32'h105,        1,1,6,32'h107};
        vt[17] = '{0,0,0,              0,0,0,              4, 1,1,0,0,              0,1,7,32'h108};
        vt[18] = '{0,0,0,              0,0,0,              7, 1,1,1,32'h108,        0,0,7,32'h108};

        rst_n = 1'b0;
        bus.mem_valid_i = 1'b1; bus.mem_addr_i = 5'd3; bus.mem_data_i = 32'h1;
        bus.alu_valid_i = 1'b1; bus.alu_addr_i = 5'd4; bus.alu_data_i = 32'h2;
        bus.fwd_addr_i  = 5'd3;
        repeat (3) @(negedge clk);
        sample_now();
        chk_reset_state("rst");
        rst_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            cyc(vt[i].mv, vt[i].ma, vt[i].md, vt[i].av, vt[i].aa, vt[i].ad, vt[i].fa);
            chk($sformatf("v%0d_mr", i),  64'(s_mr),  64'(vt[i].mr));
            chk($sformatf("v%0d_ar", i),  64'(s_ar),  64'(vt[i].ar));
            chk($sformatf("v%0d_hit", i), 64'(s_hit), 64'(vt[i].hit));
            chk($sformatf("v%0d_fd", i),  64'(s_fd),  64'(vt[i].fd));
            chk($sformatf("v%0d_cnt", i), 64'(s_cnt), 64'(vt[i].cnt));
            chk($sformatf("v%0d_wen", i), 64'(s_wen), 64'(vt[i].wen));
            chk($sformatf("v%0d_dst", i), 64'(s_dst), 64'(vt[i].dst));
            chk($sformatf("v%0d_dat", i), 64'(s_dat), 64'(vt[i].dat));
        end

        // Reset with three entries queued and a write in flight.
        cyc(1'b1, 5'd9, 32'h909, 1'b1, 5'd10, 32'h90A, 5'd0);
        cyc(1'b1, 5'd11, 32'h90B, 1'b1, 5'd12, 32'h90C, 5'd0);
        chk("mr_pre_cnt", 64'(s_cnt), 64'd3);
        chk("mr_pre_wen", 64'(s_wen), 64'd1);
        bus.mem_valid_i = 1'b1; bus.alu_valid_i = 1'b1; bus.fwd_addr_i = 5'd11;
        rst_n = 1'b0;
        sample_now();
        chk_reset_state("mrst");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b1, 5'd13, 32'h90D, 1'b0, '0, '0, 5'd11);
        chk("first_mr",  64'(s_mr),  64'd1);
        chk("first_hit", 64'(s_hit), 64'd0);
        chk("first_cnt", 64'(s_cnt), 64'd1);
        chk("first_wen", 64'(s_wen), 64'd0);
        idle(5'd13);
        chk("first_fwd", 64'(s_fd),  64'h90D);
        chk("first_w",   64'(s_wen), 64'd1);
        chk("first_dst", 64'(s_dst), 64'd13);
        chk("first_dat", 64'(s_dat), 64'h90D);
        for (int i = 0; i < 3; i++) begin
            idle(5'd11);
            chk($sformatf("post_rst%0d_wen", i), 64'(s_wen), 64'd0);
            chk($sformatf("post_rst%0d_cnt", i), 64'(s_cnt), 64'd0);
            chk($sformatf("post_rst%0d_hit", i), 64'(s_hit), 64'd0);
        end

        // Ten back-to-back writes cross the pointer wrap more than once.
        got.delete();
        for (int i = 1; i <= 12; i++) begin
            if (i <= 10) cyc(1'b1, AL'(i), 32'h1000 + WS'(i), 1'b0, '0, '0, 5'd0);
            else         idle(5'd0);
            if (s_wen) got.push_back('{a: s_dst, d: s_dat});
        end
        chk("wrap_n", 64'(got.size()), 64'd10);
        for (int i = 0; i < 10; i++) begin
            if (i < got.size()) begin
                chk($sformatf("wrap%0d_a", i), 64'(got[i].a), 64'(i + 1));
                chk($sformatf("wrap%0d_d", i), 64'(got[i].d), 64'(32'h1000 + i + 1));
            end
        end

        // Random traffic against the reference queue model.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        mq.delete();
        out_v = 1'b0; out_a = '0; out_d = '0;
        for (int i = 0; i < 400; i++) begin
            rmv = ($urandom_range(0, 3) != 0);
            rav = ($urandom_range(0, 3) != 0);
            ra  = AL'($urandom_range(0, 7));
            rb  = AL'($urandom_range(0, 7));
            rf  = AL'($urandom_range(0, 7));
            rda = $urandom;
            rdb = $urandom;

            free = DP - mq.size();
            e_mr = (free >= 1);
            e_ar = (free >= 2) || (free >= 1 && !rmv);
            e_hit = 1'b0;
            e_fd = '0;
            if (rf != 0) begin
                for (int k = mq.size() - 1; k >= 0; k--) begin
                    if (!e_hit && mq[k].a == rf) begin
                        e_hit = 1'b1;
                        e_fd  = mq[k].d;
                    end
                end
                if (!e_hit && out_v && out_a == rf) begin
                    e_hit = 1'b1;
                    e_fd  = out_d;
                end
            end

            cyc(rmv, ra, rda, rav, rb, rdb, rf);
            chk($sformatf("r%0d_mr", i),  64'(s_mr),  64'(e_mr));
            chk($sformatf("r%0d_ar", i),  64'(s_ar),  64'(e_ar));
            chk($sformatf("r%0d_hit", i), 64'(s_hit), 64'(e_hit));
            chk($sformatf("r%0d_fd", i),  64'(s_fd),  64'(e_fd));

            m_ok = rmv && e_mr;
            a_ok = rav && e_ar;
            if (mq.size() > 0) begin
                ent_t h;
                h = mq.pop_front();
                out_v = 1'b1; out_a = h.a; out_d = h.d;
            end else begin
                out_v = 1'b0;
            end
            if (m_ok && ra != 0) mq.push_back('{a: ra, d: rda});
            if (a_ok && rb != 0) mq.push_back('{a: rb, d: rdb});

            chk($sformatf("r%0d_cnt", i), 64'(s_cnt), 64'(mq.size()));
            chk($sformatf("r%0d_wen", i), 64'(s_wen), 64'(out_v));
            chk($sformatf("r%0d_dst", i), 64'(s_dst), 64'(out_a));
            chk($sformatf("r%0d_dat", i), 64'(s_dat), 64'(out_d));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
